logisim_pattern_seq: RTL and testbench
======================================

Name: logisim_pattern_seq

Overview:
Parametrised sequential successor to the current combinational Logisim demo core. It generates one of four selectable WIDTH-bit output patterns: binary count, Gray count, LFSR, or walking one. Stepping is gated by an enable and divided down by a programmable prescaler. It sits behind the 8-bit tile shell: CLK on io_in[0], RST on io_in[1], control inputs on the remaining io_in bits, and O/TICK/WRAP on io_out.

Parameters:
WIDTH, 4, pattern width in bits; legal range 2..16.
DIV, 1, number of enabled cycles per step; must be ≥1.
TAPS, 4'b1100, WIDTH-bit LFSR feedback mask; the default is maximal-length for WIDTH=4.

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous reset, active-low
EN  in  1  step enable; also gates the prescaler
MODE  in  2  0=BIN, 1=GRAY, 2=LFSR, 3=WALK
DIR  in  1  0=up/left, 1=down/right; ignored in LFSR mode
O  out  WIDTH  pattern output
TICK  out  1  registered; high for the one cycle in which a new step value is visible on O
WRAP  out  1  registered; high together with TICK when the step completed a period

Behaviour:
- Internal registers:
  - state[WIDTH-1:0]
  - mode_q[1:0]
  - pc, range 0..DIV-1, width clog2(DIV) with a minimum of 1
  - TICK, WRAP
- Output decode: O = state ^ (state>>1) in GRAY mode, otherwise O = state. O is a function of registers only; MODE is not in the decode path, which uses mode_q.
- Seed per mode: BIN=0, GRAY=0, LFSR=all-ones, WALK=1 (LSB set).
- Per-edge priority, highest first:
  1. RST=0: state<=seed(MODE), mode_q<=MODE, pc<=0, TICK<=0, WRAP<=0.
  2. MODE≠mode_q: state<=seed(MODE), mode_q<=MODE, pc<=0, TICK<=0, WRAP<=0. No step occurs, even if EN=1.
  3. (Optional load, see below.)
  4. EN=1 and pc==DIV-1: step, pc<=0, TICK<=1, WRAP<=wrap condition.
  5. EN=1 and pc<DIV-1: pc<=pc+1, TICK<=0, WRAP<=0.
  6. EN=0: pc and state hold, TICK<=0, WRAP<=0.
- Step function, all arithmetic modulo 2^WIDTH:
  - BIN/GRAY: state±1 per DIR.
  - LFSR: state<={state[WIDTH-2:0], ^(state & TAPS)}.
  - WALK: rotate left (DIR=0) or right (DIR=1) by one bit.
- Wrap condition, evaluated on the new state value:
  - BIN/GRAY up: new state==0.
  - BIN/GRAY down: new state==all-ones.
  - LFSR: new state==all-ones.
  - WALK left: new state==1.
  - WALK right: new state==MSB only.
- Latency: one cycle from the qualifying EN edge to the new O, with TICK asserted in that same cycle.
- DIV=1: a step occurs on every enabled cycle, and TICK can remain high continuously.
- DIR changes take effect on the next step; they do not touch pc or state.
- Reset asserted mid-count discards prescaler progress.
- LFSR mode never reaches all-zero.

Optional Feature:
LOGISIM_PATTERN_SEQ_LOAD_EN
- Defined:
  - Adds ports LOAD (in, 1) and D (in, WIDTH).
  - At priority 3, LOAD=1 sets state<=D, pc<=0, TICK<=0, WRAP<=0; this overrides any EN step.
  - In GRAY mode D is the binary count, so O shows gray(D).
  - In LFSR mode, D==0 loads all-ones instead.
- Undefined: LOAD and D do not exist, and priority level 3 is absent.

Test Plan:
1. WIDTH=4, DIV=1, MODE=0. Hold RST=0 for 2 cycles -> O=0, TICK=0, WRAP=0. Release with EN=1, DIR=0 -> O=1,2,…,15,0. TICK is high every cycle; WRAP=1 only in the cycle O=0.
2. BIN at O=0, set DIR=1 -> next O=15 with WRAP=1. Drop EN for 3 cycles -> O holds at 15, TICK=0.
3. Switch MODE 0->1 mid-count -> next cycle O=0, TICK=0. With EN=1 -> O=0,1,3,2,6,7,5,4,12,… and back to 0 after 16 steps with WRAP=1.
4. MODE=2, TAPS=4'b1100 -> O=1111, then 1110,1100,1000,0001,… Returns to 1111 after 15 steps with WRAP=1 on that step only; 0000 never appears.
5. MODE=3, DIR=0 -> O=0001,0010,0100,1000,0001, with WRAP on the final 0001. Then DIR=1 from 0001 -> 1000 with WRAP=1.
6. DIV=3, MODE=0, EN=1 -> a step every 3rd cycle.
   - Drop EN for 2 cycles at pc=1 -> the step is delayed by exactly 2 cycles.
   - Pulse RST=0 at pc=2 -> O=0, pc cleared, and the next step arrives 3 enabled cycles after release.
   - With the LOAD feature: LOAD=1, D=9 while EN=1 and pc=2 -> O=9, TICK=0, and the next step to 10 arrives 3 enabled cycles later.

Source files
------------

// File: rtl/logisim_pattern_seq.sv
// Selectable WIDTH-bit pattern generator (binary, Gray, LFSR, walking one) with enable and prescaler.
// Optional macro LOGISIM_PATTERN_SEQ_LOAD_EN adds a parallel load (i_load, i_d).
module logisim_pattern_seq #(
   parameter int              WIDTH = 4,
   parameter int              DIV   = 1,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(4'b1100)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic             i_dir,
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
`endif
   output logic [WIDTH-1:0] o_o,
   output logic             o_tick,
   output logic             o_wrap
);

   localparam int               PCW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PCW-1:0]   PC_LAST   = PCW'(DIV - 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] LSB_ONLY  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [1:0]       MODE_BIN  = 2'd0;
   localparam logic [1:0]       MODE_GRAY = 2'd1;
   localparam logic [1:0]       MODE_LFSR = 2'd2;
   localparam logic [1:0]       MODE_WALK = 2'd3;

   logic [WIDTH-1:0] r_state;
   logic [1:0]       r_mode;
   logic [PCW-1:0]   r_pc;
   logic             r_tick;
   logic             r_wrap;

   logic [WIDTH-1:0] w_step;
   logic             w_step_wrap;
   logic [WIDTH-1:0] w_state_next;
   logic [1:0]       w_mode_next;
   logic [PCW-1:0]   w_pc_next;
   logic             w_tick_next;
   logic             w_wrap_next;

   function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
      case (m)
         MODE_LFSR: seed = ALL_ONES;
         MODE_WALK: seed = LSB_ONLY;
         default:   seed = '0;
      endcase
   endfunction

   // Candidate next pattern value and its period-complete flag, driven by the latched mode.
   always_comb begin
      w_step      = r_state;
      w_step_wrap = 1'b0;
      case (r_mode)
         MODE_BIN, MODE_GRAY: begin
            w_step      = i_dir ? (r_state - LSB_ONLY) : (r_state + LSB_ONLY);
            w_step_wrap = i_dir ? (w_step == ALL_ONES) : (w_step == '0);
         end
         MODE_LFSR: begin
            w_step      = {r_state[WIDTH-2:0], ^(r_state & TAPS)};
            w_step_wrap = (w_step == ALL_ONES);
         end
         default: begin
            w_step      = i_dir ? {r_state[0], r_state[WIDTH-1:1]}
                                : {r_state[WIDTH-2:0], r_state[WIDTH-1]};
            w_step_wrap = i_dir ? (w_step == MSB_ONLY) : (w_step == LSB_ONLY);
         end
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_mode_next  = r_mode;
      w_pc_next    = r_pc;
      w_tick_next  = 1'b0;
      w_wrap_next  = 1'b0;
      if (i_mode != r_mode) begin
         w_state_next = seed(i_mode);
         w_mode_next  = i_mode;
         w_pc_next    = '0;
      end
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
      else if (i_load) begin
         // An all-zero LFSR would lock up, so it is replaced by the seed.
         w_state_next = ((r_mode == MODE_LFSR) && (i_d == '0)) ? ALL_ONES : i_d;
         w_pc_next    = '0;
      end
`endif
      else if (i_en) begin
         if (r_pc == PC_LAST) begin
            w_state_next = w_step;
            w_pc_next    = '0;
            w_tick_next  = 1'b1;
            w_wrap_next  = w_step_wrap;
         end else begin
            w_pc_next = r_pc + PCW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= seed(i_mode);
         r_mode  <= i_mode;
         r_pc    <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_mode  <= w_mode_next;
         r_pc    <= w_pc_next;
         r_tick  <= w_tick_next;
         r_wrap  <= w_wrap_next;
      end
   end

   assign o_o    = (r_mode == MODE_GRAY) ? (r_state ^ (r_state >> 1)) : r_state;
   assign o_tick = r_tick;
   assign o_wrap = r_wrap;

endmodule

// File: tb/tb_logisim_pattern_seq.sv
// Bench for logisim_pattern_seq: directed plan steps on DIV=1 and DIV=3 instances, then random traffic vs a model.
module tb_logisim_pattern_seq;

   logic       clk = 1'b0;
   logic       rst_n, en, dir;
   logic [1:0] mode;
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
   logic       load;
   logic [3:0] d;
`endif
   logic [3:0] o1, o3;
   logic       t1, w1, t3, w3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logisim_pattern_seq #(.WIDTH(4), .DIV(1), .TAPS(4'b1100)) u1 (
      .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_mode(mode), .i_dir(dir),
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
      .i_load(load), .i_d(d),
`endif
      .o_o(o1), .o_tick(t1), .o_wrap(w1));

   logisim_pattern_seq #(.WIDTH(4), .DIV(3), .TAPS(4'b1100)) u3 (
      .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_mode(mode), .i_dir(dir),
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
      .i_load(load), .i_d(d),
`endif
      .o_o(o3), .o_tick(t3), .o_wrap(w3));

   // Reference model: the pattern as a plain integer position, one entry per instance.
   int divs[2] = '{1, 3};
   int ms[2], mm[2], mp[2], mt[2], mw[2];

   function automatic int seed_of(int md);
      return (md == 2) ? 15 : (md == 3) ? 1 : 0;
   endfunction

   function automatic int next_of(int s, int md, bit dr);
      if (md < 2)  return dr ? (s + 15) % 16 : (s + 1) % 16;
      if (md == 2) return ((s * 2) % 16) + ($countones(s & 12) % 2);
      return dr ? ((s / 2) + (s % 2) * 8) : (((s * 2) % 16) + (s / 8));
   endfunction

   function automatic bit wrap_of(int n, int md, bit dr);
      if (md < 2)  return dr ? (n == 15) : (n == 0);
      if (md == 2) return n == 15;
      return dr ? (n == 8) : (n == 1);
   endfunction

   function automatic int shown(int k);
      return (mm[k] == 1) ? (ms[k] ^ (ms[k] / 2)) : ms[k];
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!rst_n || int'(mode) != mm[k]) begin
            ms[k] = seed_of(int'(mode)); mm[k] = int'(mode); mp[k] = 0; mt[k] = 0; mw[k] = 0;
         end
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
         else if (load) begin
            ms[k] = (mm[k] == 2 && d == 0) ? 15 : int'(d); mp[k] = 0; mt[k] = 0; mw[k] = 0;
         end
`endif
         else if (en) begin
            if (mp[k] == divs[k] - 1) begin
               ms[k] = next_of(ms[k], mm[k], dir); mp[k] = 0; mt[k] = 1;
               mw[k] = int'(wrap_of(ms[k], mm[k], dir));
            end else begin
               mp[k]++; mt[k] = 0; mw[k] = 0;
            end
         end else begin
            mt[k] = 0; mw[k] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: advance the model on the edge, then compare both instances after it.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("o_div1", {28'd0, o1}, shown(0));
      chk("tick_div1", {31'd0, t1}, mt[0]);
      chk("wrap_div1", {31'd0, w1}, mw[0]);
      chk("o_div3", {28'd0, o3}, shown(1));
      chk("tick_div3", {31'd0, t3}, mt[1]);
      chk("wrap_div3", {31'd0, w3}, mw[1]);
      $display("[TB] t=%0t rst=%0b en=%0b mode=%0d dir=%0b | div1 o=%0h tick=%0b wrap=%0b | div3 o=%0h tick=%0b wrap=%0b",
               $time, rst_n, en, mode, dir, o1, t1, w1, o3, t3, w3);
   endtask

   int gray_seq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
   int lfsr_seq[4] = '{14, 12, 8, 1};
   int walk_seq[4] = '{2, 4, 8, 1};

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 2'd0; dir = 1'b0;
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
      load = 1'b0; d = 4'd0;
`endif
      #2;
      cyc(); cyc();
      chk("reset_o", {28'd0, o1}, 0);
      chk("reset_tick", {31'd0, t1}, 0);
      chk("reset_wrap", {31'd0, w1}, 0);

      // Binary count up, DIV=1
      rst_n = 1'b1; en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         chk("bin_up_o", {28'd0, o1}, i % 16);
         chk("bin_up_tick", {31'd0, t1}, 1);
         chk("bin_up_wrap", {31'd0, w1}, (i == 16) ? 1 : 0);
      end
      dir = 1'b1; cyc();
      chk("bin_down_o", {28'd0, o1}, 15);
      chk("bin_down_wrap", {31'd0, w1}, 1);
      en = 1'b0;
      repeat (3) begin
         cyc();
         chk("hold_o", {28'd0, o1}, 15);
         chk("hold_tick", {31'd0, t1}, 0);
      end

      // Gray mode switch: no step on the switch edge even with EN=1
      mode = 2'd1; dir = 1'b0; en = 1'b1; cyc();
      chk("gray_seed_o", {28'd0, o1}, 0);
      chk("gray_seed_tick", {31'd0, t1}, 0);
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (i < 9) chk("gray_o", {28'd0, o1}, gray_seq[i]);
      end
      chk("gray_end_o", {28'd0, o1}, 0);
      chk("gray_end_wrap", {31'd0, w1}, 1);

      // LFSR
      mode = 2'd2; cyc();
      chk("lfsr_seed_o", {28'd0, o1}, 15);
      for (int i = 1; i <= 15; i++) begin
         cyc();
         if (i < 5) chk("lfsr_o", {28'd0, o1}, lfsr_seq[i-1]);
         chk("lfsr_nonzero", {31'd0, (o1 == 4'd0)}, 0);
         chk("lfsr_wrap", {31'd0, w1}, (i == 15) ? 1 : 0);
      end
      chk("lfsr_end_o", {28'd0, o1}, 15);

      // Walking one
      mode = 2'd3; dir = 1'b0; cyc();
      chk("walk_seed_o", {28'd0, o1}, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("walk_o", {28'd0, o1}, walk_seq[i]);
         chk("walk_wrap", {31'd0, w1}, (i == 3) ? 1 : 0);
      end
      dir = 1'b1; cyc();
      chk("walk_right_o", {28'd0, o1}, 8);
      chk("walk_right_wrap", {31'd0, w1}, 1);

      // DIV=3 prescaler behaviour
      mode = 2'd0; dir = 1'b0; rst_n = 1'b0; cyc();
      rst_n = 1'b1;
      cyc(); cyc();
      chk("div3_wait_tick", {31'd0, t3}, 0);
      cyc();
      chk("div3_step_o", {28'd0, o3}, 1);
      chk("div3_step_tick", {31'd0, t3}, 1);
      cyc();                               // pc=1
      en = 1'b0; cyc(); cyc();
      chk("div3_pause_o", {28'd0, o3}, 1);
      en = 1'b1; cyc();
      chk("div3_delay_tick", {31'd0, t3}, 0);
      cyc();
      chk("div3_delay_o", {28'd0, o3}, 2);
      chk("div3_delay_tick2", {31'd0, t3}, 1);
      cyc(); cyc();                        // pc=2
      rst_n = 1'b0; cyc();
      chk("div3_rst_o", {28'd0, o3}, 0);
      rst_n = 1'b1; cyc(); cyc();
      chk("div3_rst_wait", {31'd0, t3}, 0);
      cyc();
      chk("div3_rst_step", {31'd0, t3}, 1);
      chk("div3_rst_step_o", {28'd0, o3}, 1);
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
      cyc(); cyc();                        // pc=2
      load = 1'b1; d = 4'd9; cyc();
      chk("load_o", {28'd0, o3}, 9);
      chk("load_tick", {31'd0, t3}, 0);
      load = 1'b0; cyc(); cyc();
      chk("load_wait", {31'd0, t3}, 0);
      cyc();
      chk("load_step_o", {28'd0, o3}, 10);
      chk("load_step_tick", {31'd0, t3}, 1);
`endif

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rst_n = ($urandom_range(0, 31) != 0);
         en    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0)  dir = ~dir;
`ifdef LOGISIM_PATTERN_SEQ_LOAD_EN
         load = ($urandom_range(0, 15) == 0);
         d    = 4'($urandom_range(0, 15));
`endif
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
